vecmat_operand_packer: RTL



---
 rtl/vecmat_operand_packer_pkg.sv | 15 +
 rtl/vecmat_operand_packer_if.sv | 28 ++
 rtl/vecmat_operand_bank.sv | 46 ++++
 rtl/vecmat_operand_packer.sv | 94 +++++++++
 4 files changed

// File: rtl/vecmat_operand_packer_pkg.sv
// Shared constants and element-pair type for the 64-lane Q4.12 operand packer.
// Bank storage and stream interface both derive their widths from this package.
package vecmat_operand_packer_pkg;
    localparam int LANES     = 64;
    localparam int DW        = 16;
    localparam int FRAC_BITS = 12;
    localparam int VEC_W     = LANES * DW;
    localparam int LANE_W    = $clog2(LANES);
    localparam int LEN_W     = LANE_W + 1;

    typedef struct packed {
        logic [DW-1:0] weight;
        logic [DW-1:0] act;
    } elem_pair_t;
endpackage

// File: rtl/vecmat_operand_packer_if.sv
// Stream-in / vector-out bus of the operand packer.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// valid never waits on ready, and payload is held stable while valid & ~ready.
interface vecmat_operand_packer_if;
    import vecmat_operand_packer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic [DW-1:0]    in_weight;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] data_h;
    logic [VEC_W-1:0] W_h;
    logic [LEN_W-1:0] out_len;
    logic [15:0]      frame_count;

    modport slave (
        input  in_valid, in_data, in_weight, in_last, out_ready,
        output in_ready, out_valid, data_h, W_h, out_len, frame_count
    );

    modport master (
        output in_valid, in_data, in_weight, in_last, out_ready,
        input  in_ready, out_valid, data_h, W_h, out_len, frame_count
    );
endinterface

// File: rtl/vecmat_operand_bank.sv
// One ping-pong bank: lane-indexed pair write, full flag with recorded length,
// and synchronous zero-clear so every new fill starts from all-zero lanes.
module vecmat_operand_bank
    import vecmat_operand_packer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  logic [LANE_W-1:0]  wr_lane_i,
    input  elem_pair_t         wr_pair_i,
    input  logic               wr_done_i,
    input  logic               clr_i,
    output logic               full_o,
    output logic [LEN_W-1:0]   len_o,
    output logic [2*VEC_W-1:0] rd_vec_o
);
    logic [VEC_W-1:0] act_q;
    logic [VEC_W-1:0] wgt_q;
    logic             full_q;
    logic [LEN_W-1:0] len_q;

    // clr_i and wr_en_i never coincide: a full bank is not written, an empty one is not released
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            act_q  <= '0;
            wgt_q  <= '0;
            full_q <= 1'b0;
            len_q  <= '0;
        end else if (wr_en_i) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lane_i == LANE_W'(l)) begin
                    act_q[l*DW +: DW] <= wr_pair_i.act;
                    wgt_q[l*DW +: DW] <= wr_pair_i.weight;
                end
            end
            if (wr_done_i) begin
                full_q <= 1'b1;
                len_q  <= LEN_W'(wr_lane_i) + LEN_W'(1);
            end
        end
    end

    assign full_o   = full_q;
    assign len_o    = len_q;
    assign rd_vec_o = {wgt_q, act_q};
endmodule

// File: rtl/vecmat_operand_packer.sv
// Packs a serial (activation, weight) pair stream into 64-lane operand vectors
// through two ping-pong banks: one fills while the other is held for the engine.
module vecmat_operand_packer
    import vecmat_operand_packer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    vecmat_operand_packer_if.slave bus
);
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LANE_W-1:0] wr_lane_q, wr_lane_d;
    logic [15:0]       frame_q, frame_d;

    logic [1:0]         full;
    logic [1:0]         wr_en;
    logic [1:0]         clr;
    logic [LEN_W-1:0]   len    [2];
    logic [2*VEC_W-1:0] rd_vec [2];

    logic       accept;
    logic       lane_end;
    logic       rel;
    elem_pair_t pair;

    // Ready/valid come from registered bank flags only; reset just masks them
    assign bus.in_ready  = ~reset & ~full[wr_bank_q];
    assign bus.out_valid = ~reset & full[rd_bank_q];

    assign accept   = bus.in_valid & bus.in_ready;
    assign lane_end = (wr_lane_q == LANE_W'(LANES - 1)) | bus.in_last;
    assign rel      = bus.out_valid & bus.out_ready;
    assign pair     = '{weight: bus.in_weight, act: bus.in_data};

    always_comb begin
        wr_en = 2'b00;
        clr   = 2'b00;
        wr_en[wr_bank_q] = accept;
        clr[rd_bank_q]   = rel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        vecmat_operand_bank u_bank (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en[b]),
            .wr_lane_i (wr_lane_q),
            .wr_pair_i (pair),
            .wr_done_i (lane_end),
            .clr_i     (clr[b]),
            .full_o    (full[b]),
            .len_o     (len[b]),
            .rd_vec_o  (rd_vec[b])
        );
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_lane_d = wr_lane_q;
        rd_bank_d = rd_bank_q;
        frame_d   = frame_q;
        if (accept) begin
            if (lane_end) begin
                wr_lane_d = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_lane_d = wr_lane_q + LANE_W'(1);
            end
        end
        if (rel) begin
            rd_bank_d = ~rd_bank_q;
            frame_d   = frame_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_lane_q <= '0;
            frame_q   <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_lane_q <= wr_lane_d;
            frame_q   <= frame_d;
        end
    end

    assign bus.data_h      = rd_vec[rd_bank_q][VEC_W-1:0];
    assign bus.W_h         = rd_vec[rd_bank_q][2*VEC_W-1:VEC_W];
    assign bus.out_len     = len[rd_bank_q];
    assign bus.frame_count = frame_q;
endmodule
